// File: rtl/sample_feeder_if.sv
// rtl/sample_feeder_if.sv - producer write port (valid/ready) for the sample feeder
interface sample_feeder_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/sample_feeder.sv
// rtl/sample_feeder.sv - FIFO-buffered fixed-rate audio sample feeder with volume and mute
module sample_feeder #(
    parameter int DIV = 1250,
    parameter int AW  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    sample_feeder_if.slave    wr,
    input  logic [2:0]        volume,
    input  logic              mute,
    output logic [7:0]        sample,
    output logic              sample_strobe,
    output logic              underflow,
    output logic [AW:0]       level
);

    localparam int DEPTH = 1 << AW;

    logic [15:0]    rate_cnt;
    logic           tick;
    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic [7:0]     head;
    logic signed [8:0] centered;
    logic signed [8:0] scaled;
    logic [7:0]     scaled_out;

    assign tick  = (rate_cnt == 16'(DIV - 1));
    // Occupancy never exceeds DEPTH, so its top bit alone means full.
    assign full  = level[AW];
    assign empty = (level == '0);

    assign wr.in_ready = !full && reset_n;
    assign push        = wr.in_valid && wr.in_ready;
    assign pop         = tick && !empty;

    assign head = mem[rd_ptr];

    // Attenuate about midscale: recentre to signed, shift, then re-offset.
    always_comb begin
        centered   = $signed({1'b0, head}) - 9'sd128;
        scaled     = centered >>> volume;
        scaled_out = scaled[7:0] + 8'h80;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rate_cnt <= '0;
        end else if (tick) begin
            rate_cnt <= '0;
        end else begin
            rate_cnt <= rate_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sample        <= 8'h80;
            sample_strobe <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            sample_strobe <= pop;
            underflow     <= tick && empty;
            if (pop) begin
                sample <= mute ? 8'h80 : scaled_out;
            end
        end
    end

endmodule

// File: doc/sample_feeder.md
# sample_feeder

Buffers 8-bit audio samples from a producer (UART receiver, ROM player, or soft processor) and releases them at a fixed sample rate to the delta-sigma DAC stage, whose 8-bit `sample` input it drives directly. Contains a 16-entry FIFO with a valid/ready write port and a programmable sample-rate divider. It applies volume attenuation and mute about midscale (8'h80), and holds the last output sample on underflow.

## Interface
- `DIV`, 1250: clocks per sample period (50 MHz / 1250 = 40 kHz); legal range 2..65535.
- `AW`, 4: FIFO address width; depth = 2^AW entries.
- `clk`  input  1  system clock; all logic on rising edge.
- `reset_n`  input  1  reset; synchronous, active-low.
- `in_data`  input  8  offset-binary sample from producer.
- `in_valid`  input  1  producer has `in_data` available.
- `in_ready`  output  1  FIFO can accept a write this cycle.
- `volume`  input  3  attenuation: signed sample arithmetically shifted right by `volume` (0 = full scale).
- `mute`  input  1  force output to midscale.
- `sample`  output  8  offset-binary sample to DAC.
- `sample_strobe`  output  1  one-cycle pulse, high in the cycle `sample` takes a new value.
- `underflow`  output  1  one-cycle pulse: a sample tick found the FIFO empty.
- `level`  output  AW+1  current FIFO occupancy, 0..2^AW.

## Operation
- Write: a push occurs on a rising edge where `in_valid && in_ready`. `in_ready = !full && reset_n` is combinational from registered occupancy. Data is never dropped or overwritten.
- Rate counter: counts 0..DIV-1 and wraps. `tick` is asserted internally when count == DIV-1. The counter runs continuously, independent of FIFO state.
- Pop: on `tick`, if the registered occupancy is nonzero, the head entry is read and the read pointer advances. If occupancy is zero, nothing is popped, `sample` holds, and `underflow` pulses.
- Output arithmetic (on a successful pop):
  - d = head − 128, as a 9-bit signed value in range −128..127.
  - a = d >>> volume (arithmetic shift, floor rounding).
  - `sample` = a + 128, truncated to 8 bits. The result always stays within 0..255.
  - If `mute` = 1 (sampled at the pop), `sample` = 8'h80, the FIFO still pops, and `sample_strobe` still pulses.
- `volume` and `mute` are sampled only at pop; changes between ticks have no effect on the held output.
- Pointers are AW bits wide and wrap modulo 2^AW. Full and empty are decided by the AW+1-bit occupancy, not by pointer comparison alone.
- Simultaneous push and pop: occupancy stays unchanged, and both pointers advance.
- Push into an empty FIFO in the tick cycle: this is not a pop, because occupancy was 0 before the edge. The result is `underflow` = 1, and occupancy becomes 1 after the edge.
- Push when full: impossible, since `in_ready` = 0. A pop while full frees a slot, and `in_ready` rises the following cycle.

## Timing
- While `reset_n` is low at an edge:
  - `sample` = 8'h80, `sample_strobe` = 0, `underflow` = 0, `level` = 0.
  - Pointers = 0, rate counter = 0.
  - `in_ready` = 0 combinationally.
- First tick occurs in the DIV-th cycle after `reset_n` rises (counter reaches DIV-1).
- Pop latency: `sample` and `sample_strobe` update on the edge that ends the tick cycle. `underflow` uses the same edge.
- Strobe/underflow spacing: exactly DIV cycles apart in steady state, and mutually exclusive.
- `level` is registered and updates on the edge after each push or pop.
- Minimum push-to-output latency: push at edge N, eligible for pop at any tick in cycle ≥ N+1.
- Reset mid-operation: all FIFO contents are discarded. The outputs return to their reset values at the first edge with `reset_n` low, with no partial strobe.

## Test plan
- Rate and order (DIV=4, volume=0, mute=0): push 8'h10, 8'h20, 8'hF0 back-to-back. Required response:
  - `sample_strobe` every 4 cycles.
  - `sample` = 10, 20, F0.
  - A 4th tick gives `underflow` = 1 with `sample` held at F0.
- Full/backpressure (DIV=4): hold `in_valid` = 1 with incrementing data from 0. Required response:
  - `level` reaches 16 and `in_ready` = 0.
  - Each tick pops one entry and `in_ready` reopens for exactly one push.
  - The output sequence is 0, 1, 2, … with no gaps.
- Volume: push 8'hFF, 8'h00, 8'h81, 8'h7F with volume=3. Required outputs are 8F, 70, 80, 7F; with volume=7 the outputs are 80, 7F, 80, 7F.
- Mute: push 8'h20 with mute=1. Required response: `sample` = 80, `sample_strobe` pulses, and `level` decrements.
- Boundary: push into an empty FIFO in the exact tick cycle. Required response: `underflow` pulse and `sample` unchanged; the next tick outputs the pushed value.
- Reset mid-stream: with `level` = 5, drive `reset_n` low for 1 cycle. Required response:
  - `sample` = 80, `level` = 0.
  - The next strobe is not earlier than DIV cycles after release.
  - No old data appears.
